// File: rtl/adder_share_arbiter.sv
// Round-robin front end that time-shares one external combinational adder
// among NUM_REQ requesters through a two-register pipeline (operands, then sum).
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  input  logic [WIDTH:0]             add_s,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [WIDTH:0]             rsp_sum,
  output logic                       busy
);

  logic [WIDTH-1:0] op_a [NUM_REQ];
  logic [WIDTH-1:0] op_b [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_a[g] = req_a[g*WIDTH +: WIDTH];
    assign op_b[g] = req_b[g*WIDTH +: WIDTH];
  end

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [IDW-1:0]   id_p1;
  logic             vld_p2;
  logic [WIDTH:0]   sum_p2;
  logic [IDW-1:0]   id_p2;
  logic [IDW-1:0]   rr_ptr;

  logic             s2_load;
  logic             s1_free;
  logic             gnt_any;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             accept;
  logic [IDW-1:0]   ptr_next;

  assign s2_load = vld_p1 & (~vld_p2 | rsp_ready);
  assign s1_free = ~vld_p1 | s2_load;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    int j;
    logic [IDW-1:0] jj;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDW'(j);
      if (!gnt_any && req_valid[jj]) begin
        gnt_any = 1'b1;
        gnt_idx = jj;
        sel_a   = op_a[jj];
        sel_b   = op_b[jj];
      end
    end
  end

  // Gating with rst keeps req_ready low while reset is held asynchronously.
  assign accept   = gnt_any & s1_free & ~rst;
  assign ptr_next = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // Stage 1: operand capture feeding the shared adder
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      id_p1  <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      a_p1   <= sel_a;
      b_p1   <= sel_b;
      id_p1  <= gnt_idx;
      rr_ptr <= ptr_next;
    end else if (s2_load) begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage 2: registered sum presented to the consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      sum_p2 <= '0;
      id_p2  <= '0;
    end else if (s2_load) begin
      vld_p2 <= 1'b1;
      sum_p2 <= add_s;
      id_p2  <= id_p1;
    end else if (rsp_ready) begin
      vld_p2 <= 1'b0;
    end
  end

  assign add_a     = a_p1;
  assign add_b     = b_p1;
  assign rsp_valid = vld_p2;
  assign rsp_sum   = sum_p2;
  assign rsp_id    = id_p2;
  assign busy      = vld_p1 | vld_p2;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter; the shared adder is modelled inline.
module tb_adder_share_arbiter;
  localparam int NR  = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*W-1:0]   req_a;
  logic [NR*W-1:0]   req_b;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W:0]        add_s;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W:0]        rsp_sum;
  logic              busy;

  adder_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .busy(busy)
  );

  assign add_s = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int id; logic [W:0] sum; } exp_t;
  exp_t          exp_q[$];
  int            gnt_log[$];
  int            checks = 0;
  int            errors = 0;
  int            accepts = 0;
  int            wait_cnt[NR];
  logic [NR-1:0] acc_vec = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Monitor: records accepts into the scoreboard and checks every consumed response.
  always @(negedge clk) begin
    if (rst) begin
      acc_vec = '0;
      for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d sum %h, expected no response", rsp_id, rsp_sum);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
        end
      end
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      acc_vec = req_valid & req_ready;
      for (int i = 0; i < NR; i++) begin
        if (acc_vec[i]) begin
          exp_t n;
          n.id  = i;
          n.sum = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]};
          exp_q.push_back(n);
          gnt_log.push_back(i);
          accepts++;
          chk("starvation", 64'(wait_cnt[i] <= NR-1), 64'd1);
          wait_cnt[i] = 0;
        end
      end
      if (acc_vec != '0)
        for (int i = 0; i < NR; i++)
          if (req_valid[i] && !acc_vec[i]) wait_cnt[i]++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc0;
    logic [W:0] held;
    int rr_exp[5];
    int wrap_exp[4];
    int n;
    rr_exp   = '{0, 1, 2, 3, 0};
    wrap_exp = '{3, 1, 3, 0};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("reset_add_a", 64'(add_a), 64'd0);
    rst = 1'b0;
    tick();

    // Single op with carry-out from requester 2
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0001);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    chk("single_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    tick();
    chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("single_rsp_id", 64'(rsp_id), 64'd2);
    chk("single_rsp_sum", 64'(rsp_sum), 64'h1_0000_0000);
    tick();
    tick();

    // Two ops in flight, then asynchronous reset discards them
    for (int i = 0; i < NR; i++) set_op(i, 32'hAAAA_0000 + 32'(i), 32'h1);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_add_a", 64'(add_a), 64'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);

    // Round robin from pointer 0 with everyone requesting
    for (int i = 0; i < NR; i++) set_op(i, 32'(i), 32'h10);
    base = gnt_log.size();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (t >= 1) begin
        chk("rr_rsp_sum", 64'(rsp_sum), 64'h10 + 64'(t - 1));
        chk("rr_rsp_id", 64'(rsp_id), 64'(t - 1));
      end
    end
    req_valid = '0;
    chk("rr_count", 64'(gnt_log.size() - base), 64'd5);
    for (int k = 0; k < 5; k++)
      if (base + k < gnt_log.size()) chk("rr_order", 64'(gnt_log[base + k]), 64'(rr_exp[k]));
    for (int t = 0; t < 4; t++) tick();

    // Backpressure: pointer sits at 1, so requester 1 (0x100+5) is first
    for (int i = 0; i < NR; i++) set_op(i, 32'h100 * 32'(i), 32'h5);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    acc0 = accepts;
    held = '0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (t == 1) held = rsp_sum;
    end
    chk("bp_first_sum", 64'(held), 64'h105);
    chk("bp_accepts", 64'(accepts - acc0), 64'd2);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    chk("bp_sum_stable", 64'(rsp_sum), 64'(held));
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    acc0 = accepts;
    for (int t = 0; t < 4; t++) tick();
    chk("bp_resume_rate", 64'(accepts - acc0), 64'd4);
    req_valid = '0;
    for (int t = 0; t < 4; t++) tick();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Sparse requests exercising pointer wrap
    base = gnt_log.size();
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1001;
    tick();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    chk("wrap_count", 64'(gnt_log.size() - base), 64'd4);
    for (int k = 0; k < 4; k++)
      if (base + k < gnt_log.size()) chk("wrap_order", 64'(gnt_log[base + k]), 64'(wrap_exp[k]));
    for (int t = 0; t < 3; t++) tick();

    // Random traffic; a requester holds valid and operands until accepted
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || acc_vec[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_op(i, $urandom, $urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
